// File: rtl/DataTypes_pkg.sv
// Shared types for the data memory responder: FSM states, RISC-V funct3
// width codes and a helper that reduces funct3 to an access size.
package DataTypes_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Undefined codes (011, 110, 111) fall into the word bucket, as loads treat them.
  function automatic logic [1:0] size_code(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_code = SZ_BYTE;
      2'b01:   size_code = SZ_HALF;
      default: size_code = SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_load_extend.sv
// load_extend: selects the addressed byte/halfword lane of a memory word and
// sign- or zero-extends it according to the load funct3.
module load_extend
  import DataTypes_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[8*offset +: 8];
    half_v = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      LB:      data = {{24{byte_v[7]}}, byte_v};
      LH:      data = {{16{half_v[15]}}, half_v};
      LBU:     data = {24'd0, byte_v};
      LHU:     data = {16'd0, half_v};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory for a RISC-V datapath: one access in flight,
// byte-enabled stores, extended loads. MEM_MISALIGN_CHECK_EN enables faulting.
module data_mem_responder
  import DataTypes_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        misaligned
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q, wdata_q;
  logic        we_q;
  logic [2:0]  funct3_q;

  logic [31:0] src_addr, src_wdata;
  logic        src_we;
  logic [2:0]  src_f3;
  logic [1:0]  size, off;
  logic        fault, to_resp;
  logic [AW-1:0] idx;
  logic [3:0]  be;
  logic [31:0] wlanes, ld_data;
  logic        unused_bits;

  logic [31:0] mem [DEPTH_WORDS];

  // With LATENCY=1 the response is built straight from the live request.
  always_comb begin
    src_addr  = (state == IDLE) ? addr   : addr_q;
    src_wdata = (state == IDLE) ? wdata  : wdata_q;
    src_we    = (state == IDLE) ? we     : we_q;
    src_f3    = (state == IDLE) ? funct3 : funct3_q;
  end

  assign size        = size_code(src_f3);
  assign idx         = src_addr[AW+1:2];
  assign unused_bits = ^src_addr[31:AW+2];
  assign to_resp     = (state == IDLE && req && LATENCY == 1) ||
                       (state == WAIT && cnt == 4'd1);

  always_comb begin
`ifdef MEM_MISALIGN_CHECK_EN
    fault = (size == SZ_HALF && src_addr[0]) ||
            (size == SZ_WORD && src_addr[1:0] != 2'b00);
    off   = src_addr[1:0];
`else
    fault = 1'b0;
    case (size)
      SZ_BYTE: off = src_addr[1:0];
      SZ_HALF: off = {src_addr[1], 1'b0};
      default: off = 2'b00;
    endcase
`endif
  end

  always_comb begin
    be     = 4'b0000;
    wlanes = src_wdata;
    case (src_f3)
      SB: begin
        be     = 4'b0001 << off;
        wlanes = {4{src_wdata[7:0]}};
      end
      SH: begin
        be     = off[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{src_wdata[15:0]}};
      end
      SW:      be = 4'b1111;
      default: be = 4'b0000;
    endcase
    if (fault) be = 4'b0000;
  end

  load_extend u_load_extend (
    .funct3 (src_f3),
    .offset (off),
    .word   (mem[idx]),
    .data   (ld_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      ready      <= 1'b0;
      rdata      <= 32'd0;
      misaligned <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      we_q       <= 1'b0;
      funct3_q   <= 3'd0;
    end else begin
      ready      <= to_resp;
      misaligned <= to_resp && fault;
      rdata      <= (to_resp && !src_we && !fault) ? ld_data : 32'd0;
      case (state)
        IDLE: begin
          if (req) begin
            addr_q   <= addr;
            wdata_q  <= wdata;
            we_q     <= we;
            funct3_q <= funct3;
            cnt      <= 4'(LATENCY - 1);
            state    <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            cnt   <= 4'd0;
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stores commit on the edge leaving RESP; an async reset forces IDLE first, dropping it.
  always_ff @(posedge clk) begin
    if (state == RESP && src_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: a LATENCY=2 instance for functional/reset cases and a
// LATENCY=1, 16-word instance driven with req held high.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // LATENCY=2 instance
  logic        rst2, req2, we2;
  logic [2:0]  f3_2;
  logic [31:0] addr2, wdata2, rdata2;
  logic        ready2, mis2;

  // LATENCY=1 instance
  logic        rst1, req1, we1;
  logic [2:0]  f3_1;
  logic [31:0] addr1, wdata1, rdata1;
  logic        ready1, mis1;

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst2), .req(req2), .we(we2), .funct3(f3_2), .addr(addr2),
    .wdata(wdata2), .rdata(rdata2), .ready(ready2), .misaligned(mis2)
  );

  data_mem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst1), .req(req1), .we(we1), .funct3(f3_1), .addr(addr1),
    .wdata(wdata1), .rdata(rdata1), .ready(ready1), .misaligned(mis1)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // One access on dut2. lat counts rising edges from the accepting edge to the
  // first edge after which ready is seen; post_* samples the following cycle.
  task automatic access2(input logic w, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rd, output logic mis,
                         output int lat, output logic post_ready, output logic [31:0] post_rd);
    @(negedge clk);
    req2 = 1'b1; we2 = w; f3_2 = f; addr2 = a; wdata2 = d;
    @(posedge clk); #1;
    req2 = 1'b0;
    lat = 1;
    while (!ready2 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd  = rdata2;
    mis = mis2;
    @(posedge clk); #1;
    post_ready = ready2;
    post_rd    = rdata2;
  endtask

  logic [31:0] rd, prd;
  logic        mis, prdy, seen;
  int          lat;

  logic        v_we   [8];
  logic [2:0]  v_f3   [8];
  logic [31:0] v_addr [8];
  logic [31:0] v_wd   [8];
  logic [31:0] v_exp  [8];

  initial begin
    rst2 = 1'b0; req2 = 1'b0; we2 = 1'b0; f3_2 = 3'd0; addr2 = 32'd0; wdata2 = 32'd0;
    rst1 = 1'b0; req1 = 1'b0; we1 = 1'b0; f3_1 = 3'd0; addr1 = 32'd0; wdata1 = 32'd0;

    // Reset state
    #12;
    check("reset_ready", {31'd0, ready2}, 32'd0);
    check("reset_rdata", rdata2, 32'd0);
    check("reset_misaligned", {31'd0, mis2}, 32'd0);
    check("reset_ready_l1", {31'd0, ready1}, 32'd0);
    @(negedge clk); rst2 = 1'b1;

    // SW 0xDEADBEEF to 0x10, then LW: ready on the third cycle counting the req cycle
    access2(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, mis, lat, prdy, prd);
    check("sw_latency", 32'(lat), 32'd2);
    check("sw_rdata_zero", rd, 32'd0);
    check("sw_misaligned", {31'd0, mis}, 32'd0);
    access2(1'b0, 3'b010, 32'h10, 32'd0, rd, mis, lat, prdy, prd);
    check("lw_latency", 32'(lat), 32'd2);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_ready_one_cycle", {31'd0, prdy}, 32'd0);
    check("lw_rdata_after_resp", prd, 32'd0);

    // SB 0x80 to 0x13 over a zero word
    access2(1'b1, 3'b010, 32'h10, 32'h0, rd, mis, lat, prdy, prd);
    access2(1'b1, 3'b000, 32'h13, 32'hFFFFFF80, rd, mis, lat, prdy, prd);
    access2(1'b0, 3'b000, 32'h13, 32'd0, rd, mis, lat, prdy, prd);
    check("lb_sign", rd, 32'hFFFFFF80);
    access2(1'b0, 3'b100, 32'h13, 32'd0, rd, mis, lat, prdy, prd);
    check("lbu_zero", rd, 32'h00000080);
    access2(1'b0, 3'b010, 32'h10, 32'd0, rd, mis, lat, prdy, prd);
    check("lw_after_sb", rd, 32'h80000000);

    // Address wrap: 4096 bytes above 0x10 aliases the same word
    access2(1'b0, 3'b010, 32'h1010, 32'd0, rd, mis, lat, prdy, prd);
    check("lw_wrap", rd, 32'h80000000);

    // Undefined funct3: store writes nothing, load reads as LW
    access2(1'b1, 3'b011, 32'h10, 32'hFFFFFFFF, rd, mis, lat, prdy, prd);
    access2(1'b0, 3'b111, 32'h10, 32'd0, rd, mis, lat, prdy, prd);
    check("undef_f3_no_write_lw", rd, 32'h80000000);

    // Halfword stores and loads in word 0x20
    access2(1'b1, 3'b010, 32'h20, 32'h0, rd, mis, lat, prdy, prd);
    access2(1'b1, 3'b001, 32'h22, 32'h00001234, rd, mis, lat, prdy, prd);
    access2(1'b0, 3'b010, 32'h20, 32'd0, rd, mis, lat, prdy, prd);
    check("lw_after_sh", rd, 32'h12340000);
    access2(1'b1, 3'b001, 32'h20, 32'h0000F00D, rd, mis, lat, prdy, prd);
    access2(1'b0, 3'b001, 32'h20, 32'd0, rd, mis, lat, prdy, prd);
    check("lh_sign", rd, 32'hFFFFF00D);
    access2(1'b0, 3'b101, 32'h20, 32'd0, rd, mis, lat, prdy, prd);
    check("lhu_zero", rd, 32'h0000F00D);
    access2(1'b0, 3'b010, 32'h20, 32'd0, rd, mis, lat, prdy, prd);
    check("lw_two_halves", rd, 32'h1234F00D);

    // Misaligned word load from 0x06
    access2(1'b1, 3'b010, 32'h04, 32'h11223344, rd, mis, lat, prdy, prd);
    access2(1'b0, 3'b010, 32'h06, 32'd0, rd, mis, lat, prdy, prd);
`ifdef MEM_MISALIGN_CHECK_EN
    check("lw_misaligned_rdata", rd, 32'd0);
    check("lw_misaligned_flag", {31'd0, mis}, 32'd1);
`else
    check("lw_misaligned_rdata", rd, 32'h11223344);
    check("lw_misaligned_flag", {31'd0, mis}, 32'd0);
`endif
    access2(1'b0, 3'b000, 32'h06, 32'd0, rd, mis, lat, prdy, prd);
    check("lb_byte2", rd, 32'h00000022);

    // Reset pulsed during WAIT of an SW to 0x30
    access2(1'b1, 3'b010, 32'h30, 32'h55AA55AA, rd, mis, lat, prdy, prd);
    @(negedge clk);
    req2 = 1'b1; we2 = 1'b1; f3_2 = 3'b010; addr2 = 32'h30; wdata2 = 32'h12345678;
    @(posedge clk); #1;
    req2 = 1'b0;
    rst2 = 1'b0;
    #2;
    check("mid_reset_ready", {31'd0, ready2}, 32'd0);
    check("mid_reset_rdata", rdata2, 32'd0);
    @(negedge clk); rst2 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ready2) seen = 1'b1;
    end
    check("aborted_no_ready", {31'd0, seen}, 32'd0);
    access2(1'b0, 3'b010, 32'h30, 32'd0, rd, mis, lat, prdy, prd);
    check("aborted_store_dropped", rd, 32'h55AA55AA);

    // LATENCY=1 with req held high: one access every two cycles
    v_we   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    v_f3   = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b010, 3'b100, 3'b001};
    v_addr = '{32'h00, 32'h44, 32'h00, 32'h04, 32'h01, 32'h00, 32'h05, 32'h02};
    v_wd   = '{32'hA5A5A5A5, 32'h01020304, 32'h0, 32'h0, 32'h7F, 32'h0, 32'h0, 32'h0};
    v_exp  = '{32'h0, 32'h0, 32'hA5A5A5A5, 32'h01020304, 32'h0, 32'hA5A57FA5,
               32'h00000003, 32'hFFFFA5A5};
    @(negedge clk);
    req1 = 1'b1; we1 = v_we[0]; f3_1 = v_f3[0]; addr1 = v_addr[0]; wdata1 = v_wd[0];
    rst1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check($sformatf("l1_ready_%0d", k), {31'd0, ready1}, 32'd1);
      check($sformatf("l1_rdata_%0d", k), rdata1, v_exp[k]);
      check($sformatf("l1_misaligned_%0d", k), {31'd0, mis1}, 32'd0);
      if (k < 7) begin
        we1 = v_we[k+1]; f3_1 = v_f3[k+1]; addr1 = v_addr[k+1]; wdata1 = v_wd[k+1];
      end else begin
        req1 = 1'b0;
      end
      @(posedge clk); #1;
      check($sformatf("l1_gap_%0d", k), {31'd0, ready1}, 32'd0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
